div_unit: RTL

- Iterative 32-bit divider in the EX stage, implementing RISC-V M-extension DIV/DIVU/REM/REMU semantics.
- Accepts an operation from EX and computes one quotient bit per cycle (radix-2 restoring).
- Drives the EX stall request into the pipeline stall controller, which freezes PC/IF/ID/EX until the result is ready.
- Returns quotient and remainder to EX for writeback selection.

---
 rtl/div_if.sv | 20 ++
 rtl/div_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: EX-stage divide request/result bundle between the pipeline and div_unit.
interface div_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             annul_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             ready_o;
  logic             stallreq_o;
  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  quotient_o, remainder_o, ready_o, stallreq_o
  );
  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output quotient_o, remainder_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32-bit divider with RISC-V DIV/DIVU/REM/REMU semantics.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic   clk,
  input logic   rst,
  div_if.slave  d
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, dvd_r, dsr_r, quot, remd;
  logic             q_neg, r_neg;
  logic             accept, neg_a, neg_b, div0, ovf, last, ge;
  logic [WIDTH-1:0] mag_a, mag_b, rem_nx, dvd_nx;
  logic [WIDTH:0]   sh, diff;
  assign accept = state == IDLE && d.start_i && !d.annul_i;
  assign neg_a  = d.signed_i && d.dividend_i[WIDTH-1];
  assign neg_b  = d.signed_i && d.divisor_i[WIDTH-1];
  assign mag_a  = neg_a ? -d.dividend_i : d.dividend_i;
  assign mag_b  = neg_b ? -d.divisor_i : d.divisor_i;
  assign div0   = d.divisor_i == '0;
  assign ovf    = d.signed_i && d.dividend_i == {1'b1, {(WIDTH-1){1'b0}}} && d.divisor_i == '1;
  assign last   = cnt == CNT_W'(WIDTH - 1);
  // Quotient bits shift into the vacated low end of the dividend register.
  assign sh     = {rem_r, dvd_r[WIDTH-1]};
  assign diff   = sh - {1'b0, dsr_r};
  assign ge     = !diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign dvd_nx = {dvd_r[WIDTH-2:0], ge};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ((div0 || ovf) ? DONE : BUSY) : IDLE;
      BUSY:    state_nx = d.annul_i ? IDLE : (last ? DONE : BUSY);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      dsr_r <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      quot  <= '0;
      remd  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        q_neg <= neg_a ^ neg_b;
        r_neg <= neg_a;
        cnt   <= '0;
        rem_r <= '0;
        dvd_r <= mag_a;
        dsr_r <= mag_b;
        if (div0) begin
          quot <= '1;
          remd <= d.dividend_i;
        end else if (ovf) begin
          quot <= {1'b1, {(WIDTH-1){1'b0}}};
          remd <= '0;
        end
      end else if (state == BUSY && !d.annul_i) begin
        rem_r <= rem_nx;
        dvd_r <= dvd_nx;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          quot <= q_neg ? -dvd_nx : dvd_nx;
          remd <= r_neg ? -rem_nx : rem_nx;
        end
      end
    end
  end
  assign d.stallreq_o  = !rst && (accept || (state == BUSY && !d.annul_i));
  assign d.ready_o     = state == DONE;
  assign d.quotient_o  = quot;
  assign d.remainder_o = remd;
endmodule
